// File: rtl/uart_pkg.sv
// Shared types and helpers for the word-level UART transmitter and its byte engine.
package uart_pkg;

    typedef enum logic [1:0] {W_IDLE, W_LOAD, W_SEND} word_state_t;
    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // 'A' - 10 == 8'h37, so A..F map onto 0x41..0x46.
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start pulse latches data, line driven from a register,
// done pulses during the last cycle of the stop bit.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    if (CLKS_PER_BIT < 2) begin : g_cpb_check
        $error("uart_tx_byte: CLKS_PER_BIT must be at least 2");
    end

    localparam int DIV_W = $clog2(CLKS_PER_BIT);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

    bit_state_t       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic             tx_q, tx_d;
    logic [7:0]       sh_q;
    logic             load_sh, shift_sh, bit_end;

    assign bit_end = (div_q == DIV_LAST);

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        tx_d     = tx_q;
        done     = 1'b0;
        load_sh  = 1'b0;
        shift_sh = 1'b0;
        unique case (state_q)
            B_IDLE: begin
                tx_d = 1'b1;
                if (start) begin
                    state_d = B_START;
                    div_d   = '0;
                    tx_d    = 1'b0;
                    load_sh = 1'b1;
                end
            end
            B_START: begin
                if (bit_end) begin
                    state_d = B_DATA;
                    div_d   = '0;
                    bit_d   = '0;
                    tx_d    = sh_q[0];
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            B_DATA: begin
                if (bit_end) begin
                    div_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = B_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        // sh_q[0] is the bit now on the line; the next one sits at [1].
                        bit_d    = bit_q + 3'd1;
                        tx_d     = sh_q[1];
                        shift_sh = 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            B_STOP: begin
                if (bit_end) begin
                    state_d = B_IDLE;
                    div_d   = '0;
                    done    = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = B_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= B_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load_sh) begin
            sh_q <= data;
        end else if (shift_sh) begin
            sh_q <= {1'b0, sh_q[7:1]};
        end
    end

    assign tx = tx_q;

endmodule

// File: rtl/uart_word_tx.sv
// Accepts one 32-bit word over valid/ready and sends it as hex text + CR LF
// or as four little-endian raw bytes through uart_tx_byte.
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234,
    parameter int HEX_MODE     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] word_i,
    input  logic        word_valid,
    output logic        word_ready,
    output logic        uart_tx,
    output logic        busy
);

    localparam logic [3:0] LAST_IDX = (HEX_MODE != 0) ? 4'd9 : 4'd3;

    word_state_t state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] shadow;
    logic        byte_start_p1;
    logic        byte_done;
    logic        accept;
    logic [7:0]  byte_data;
    logic [4:0]  nib_lsb, raw_lsb;

    assign accept = word_valid && word_ready;
    assign busy   = (state_q != W_IDLE);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        word_ready = 1'b0;
        unique case (state_q)
            W_IDLE: begin
                word_ready = 1'b1;
                if (word_valid) begin
                    state_d = W_LOAD;
                    idx_d   = '0;
                end
            end
            W_LOAD: state_d = W_SEND;
            W_SEND: begin
                if (byte_done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = W_IDLE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = W_LOAD;
                    end
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    // The start pulse is registered, so byte 0 starts on the 2nd edge after acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= W_IDLE;
            idx_q         <= '0;
            byte_start_p1 <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            byte_start_p1 <= (state_q == W_LOAD);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            shadow <= word_i;
        end
    end

    always_comb begin
        byte_data = 8'h00;
        nib_lsb   = 5'd28 - {idx_q[2:0], 2'b00};
        raw_lsb   = {idx_q[1:0], 3'b000};
        if (HEX_MODE != 0) begin
            if (idx_q < 4'd8) begin
                byte_data = nibble_to_ascii(shadow[nib_lsb +: 4]);
            end else if (idx_q == 4'd8) begin
                byte_data = ASCII_CR;
            end else begin
                byte_data = ASCII_LF;
            end
        end else begin
            byte_data = shadow[raw_lsb +: 8];
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk  (clk),
        .rst  (rst),
        .start(byte_start_p1),
        .data (byte_data),
        .tx   (uart_tx),
        .done (byte_done)
    );

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: one hex-mode and one raw-mode instance, mid-bit UART
// monitors feeding a scoreboard built from a text/byte-level reference model.
module tb_uart_word_tx;

    localparam int CPB = 4;

    logic        clk;
    logic        rst;
    logic [31:0] word_h, word_r;
    logic        valid_h, valid_r;
    logic        ready_h, ready_r;
    logic        tx_h, tx_r;
    logic        busy_h, busy_r;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] q_hex[$];
    logic [7:0] q_raw[$];

    uart_word_tx #(.CLKS_PER_BIT(CPB), .HEX_MODE(1)) dut_hex (
        .clk(clk), .rst(rst), .word_i(word_h), .word_valid(valid_h),
        .word_ready(ready_h), .uart_tx(tx_h), .busy(busy_h)
    );

    uart_word_tx #(.CLKS_PER_BIT(CPB), .HEX_MODE(0)) dut_raw (
        .clk(clk), .rst(rst), .word_i(word_r), .word_valid(valid_r),
        .word_ready(ready_r), .uart_tx(tx_r), .busy(busy_r)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic line_of(input bit hex);
        return hex ? tx_h : tx_r;
    endfunction

    function automatic logic rdy(input bit hex);
        return hex ? ready_h : ready_r;
    endfunction

    function automatic logic bsy(input bit hex);
        return hex ? busy_h : busy_r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the byte stream a word should produce on the wire.
    function automatic void push_expected(input bit hex, input logic [31:0] w);
        int n;
        if (hex) begin
            for (int i = 0; i < 8; i++) begin
                n = int'((w >> (28 - 4 * i)) & 32'hF);
                if (n < 10) q_hex.push_back(8'(48 + n));
                else        q_hex.push_back(8'(65 + n - 10));
            end
            q_hex.push_back(8'd13);
            q_hex.push_back(8'd10);
        end else begin
            for (int i = 0; i < 4; i++) q_raw.push_back(8'((w >> (8 * i)) & 32'hFF));
        end
    endfunction

    // UART receiver: finds a start bit, then samples each bit in its middle.
    task automatic rx_frame(input bit hex);
        logic [7:0] b;
        logic [7:0] exp;
        logic       start_mid, stop_bit;
        bit         aborted;
        @(negedge clk);
        if (rst || line_of(hex) !== 1'b0) return;
        aborted = 1'b0;
        b = '0;
        repeat (CPB / 2) begin @(negedge clk); if (rst) aborted = 1'b1; end
        start_mid = line_of(hex);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) begin @(negedge clk); if (rst) aborted = 1'b1; end
            b[i] = line_of(hex);
        end
        repeat (CPB) begin @(negedge clk); if (rst) aborted = 1'b1; end
        stop_bit = line_of(hex);
        if (aborted) return;
        check(hex ? "hex_start_bit" : "raw_start_bit", start_mid, 1'b0);
        if ((hex && q_hex.size() == 0) || (!hex && q_raw.size() == 0)) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_unexpected_byte: got %0h, expected no byte", hex ? "hex" : "raw", b);
        end else begin
            if (hex) exp = q_hex.pop_front();
            else     exp = q_raw.pop_front();
            check(hex ? "hex_byte" : "raw_byte", b, exp);
        end
        check(hex ? "hex_stop_bit" : "raw_stop_bit", stop_bit, 1'b1);
    endtask

    initial begin : mon_hex
        forever rx_frame(1'b1);
    end

    initial begin : mon_raw
        forever rx_frame(1'b0);
    end

    task automatic accept_word(input bit hex, input logic [31:0] w);
        int guard;
        guard = 0;
        @(negedge clk);
        if (hex) begin word_h = w; valid_h = 1'b1; end
        else     begin word_r = w; valid_r = 1'b1; end
        while (!rdy(hex) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) check("accept_wait_expired", {31'd0, rdy(hex)}, 32'd1);
        @(posedge clk);
        push_expected(hex, w);
    endtask

    // Counts negedges after the acceptance edge until word_ready is seen high.
    task automatic measure(input bit hex);
        int cnt;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) begin
                check("busy_after_accept", bsy(hex), 1'b1);
                check("ready_after_accept", rdy(hex), 1'b0);
            end
            if (cnt == 2) check("line_idle_before_start", line_of(hex), 1'b1);
            if (cnt == 3) check("start_bit_latency", line_of(hex), 1'b0);
        end while (!rdy(hex) && cnt < 3000);
        check(hex ? "hex_ready_latency" : "raw_ready_latency", cnt,
              (hex ? 10 : 4) * (10 * CPB + 2) + 1);
    endtask

    task automatic send_word(input bit hex, input logic [31:0] w);
        accept_word(hex, w);
        #1;
        if (hex) valid_h = 1'b0;
        else     valid_r = 1'b0;
        measure(hex);
    endtask

    initial begin : stim
        int lows;
        int guard;
        logic [31:0] w;
        rst = 1'b1;
        valid_h = 1'b0; valid_r = 1'b0;
        word_h = '0;    word_r = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_tx_hex", tx_h, 1'b1);
        check("reset_ready_hex", ready_h, 1'b1);
        check("reset_busy_hex", busy_h, 1'b0);
        check("reset_tx_raw", tx_r, 1'b1);
        check("reset_ready_raw", ready_r, 1'b1);
        check("reset_busy_raw", busy_r, 1'b0);
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (!tx_h || !tx_r) lows++;
        end
        check("idle_line_low_cycles", lows, 0);

        send_word(1'b1, 32'hDEADBEEF);
        send_word(1'b0, 32'h12345678);
        send_word(1'b1, 32'h09AF0A9F);

        // Word held valid while busy: only taken in the ready cycle.
        accept_word(1'b1, 32'h00000001);
        #1 word_h = 32'hFFFFFFFF;
        measure(1'b1);
        @(posedge clk);
        push_expected(1'b1, 32'hFFFFFFFF);
        #1;
        check("b2b_accept_busy", busy_h, 1'b1);
        valid_h = 1'b0;
        measure(1'b1);

        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(0, 7)) @(negedge clk);
            send_word(1'b1, $urandom);
        end
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 7)) @(negedge clk);
            w = $urandom;
            if (k == 0) w[7:0] = 8'h00;
            if (k == 1) w[31:24] = 8'hFF;
            send_word(1'b0, w);
        end

        // Reset in the data bits of byte 2; the partial word is dropped.
        accept_word(1'b1, $urandom);
        #1 valid_h = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        q_hex.delete();
        #1;
        check("tx_high_in_reset", tx_h, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_busy", busy_h, 1'b0);
        check("post_reset_ready", ready_h, 1'b1);
        check("post_reset_tx", tx_h, 1'b1);
        repeat (50) @(negedge clk);
        send_word(1'b1, 32'hC0FFEE42);

        guard = 0;
        while ((q_hex.size() != 0 || q_raw.size() != 0) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("hex_bytes_outstanding", q_hex.size(), 0);
        check("raw_bytes_outstanding", q_raw.size(), 0);
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_word_tx.md
# uart_word_tx

Serializes 32-bit result words from the core onto the board UART TX pin as 8N1 frames. Sits directly downstream of the core's `tx_word` output, replacing raw pin wiring with a valid/ready handshake. Each accepted word is sent either as printable hex plus CR LF (debug console) or as 4 raw bytes (host tooling). One word is in flight at a time; no FIFO.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 234: clock cycles per UART bit (27 MHz / 115200); legal range ≥ 2.
- `HEX_MODE`, default 1:
  - 1: send 8 ASCII hex chars, MSB nibble first, uppercase, then 0x0D 0x0A (10 bytes).
  - 0: send 4 raw bytes, little-endian (byte 0 first).

Ports:
- `clk` input 1: system clock; all logic on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `word_i` input 32: word to transmit; sampled only on acceptance.
- `word_valid` input 1: upstream has a word; must hold `word_i` stable until accepted.
- `word_ready` output 1: block can accept a word.
- `uart_tx` output 1: serial line, idle high.
- `busy` output 1: high from acceptance until the last stop bit completes.

## Operation

- **Acceptance:** occurs on the edge where `word_valid && word_ready`.
  - `word_i` is captured into a 32-bit shadow register.
  - Byte index resets to 0.
  - `word_ready` drops and `busy` rises on that same edge.
- **`word_valid` while busy:** ignored (`word_ready` = 0). Upstream holds the word.
- **Word FSM:**
  - IDLE: `word_ready`=1. On acceptance → LOAD.
  - LOAD: present byte[idx] to the byte transmitter with a 1-cycle start pulse → SEND.
  - SEND: wait for byte done.
    - If idx = last (9 in hex mode, 3 in raw mode) → IDLE.
    - Else idx++ → LOAD.
- **Byte selection:**
  - Hex mode, idx 0..7: nibble `word[31-4*idx -: 4]`.
    - 0–9 → 0x30+n.
    - A–F → 0x41+(n-10).
  - Hex mode, idx 8 → 0x0D; idx 9 → 0x0A.
  - Raw mode: byte idx → `word[8*idx +: 8]`.
- **Byte transmitter FSM:**
  - States: IDLE, START, DATA, STOP.
  - START drives 0; DATA drives 8 bits LSB first; STOP drives 1. Each state lasts `CLKS_PER_BIT` cycles.
  - The bit counter (0..7) and clock divider (0..CLKS_PER_BIT-1) reload at each bit boundary.
  - `done` pulses 1 cycle at the end of the stop bit.
- **`uart_tx`:** driven from a register (glitch-free). It is 1 in every state other than START and DATA.

## Timing

- **Reset values:** `uart_tx`=1, `word_ready`=1, `busy`=0. Both FSMs are IDLE and all counters are 0.
- **Reset mid-frame:** `uart_tx` goes high immediately (async). The partial word is discarded and not resumed.
- **Start latency:** the start bit of byte 0 is driven from the 2nd edge after the acceptance edge (acceptance → LOAD → START).
- **Frame length:** each frame is exactly 10×`CLKS_PER_BIT` cycles.
- **Inter-frame gap:** exactly 2 cycles of idle-high between frames (done → LOAD → START).
- **Word completion:** `busy` falls and `word_ready` rises on the edge after the final `done` pulse.
  - Back-to-back words: if `word_valid` is held high, the next acceptance occurs in that same ready cycle.
- **Total time, acceptance to ready:**
  - Hex mode: 10×(10×CPB+2)+1 cycles.
  - Raw mode: 4×(10×CPB+2)+1 cycles.
- **`CLKS_PER_BIT` < 2:** elaboration-time error.

## Structure

- **Shared package `uart_pkg`:**
  - `word_state_t` {IDLE, LOAD, SEND}.
  - `bit_state_t` {IDLE, START, DATA, STOP}.
  - Constants `ASCII_CR`=8'h0D, `ASCII_LF`=8'h0A.
  - Function `nibble_to_ascii`.
- **Sub-module `uart_tx_byte`:**
  - Parameter `CLKS_PER_BIT`.
  - Ports: `clk`, `rst`, `start`, `data[7:0]`, `tx`, `done`.
  - Reusable by the existing UART test logic.
- **Top `uart_word_tx`:** holds the word FSM, shadow register, byte index, and byte mux.

## Test plan

Run with `CLKS_PER_BIT`=4 and a bench UART monitor that samples mid-bit.

1. **Reset:** assert `rst` for 3 cycles, then release.
   - `uart_tx`=1, `word_ready`=1, `busy`=0; line stays high for 100 cycles.
2. **Hex mode:** `HEX_MODE`=1, word 0xDEADBEEF.
   - Monitor decodes 0x44 0x45 0x41 0x44 0x42 0x45 0x45 0x46 0x0D 0x0A.
   - `word_ready` returns exactly 421 cycles after acceptance.
3. **Raw mode:** `HEX_MODE`=0, word 0x12345678.
   - Bytes 0x78 0x56 0x34 0x12; ready after 169 cycles.
   - First start bit begins 2 cycles after acceptance.
4. **Valid while busy:** present 0x00000001, then change `word_i` to 0xFFFFFFFF with `word_valid` held during transmission.
   - First output is "00000001\r\n"; the second word is accepted only on the ready cycle.
   - In hex mode it yields "FFFFFFFF\r\n".
5. **Reset mid-byte:** assert `rst` during the DATA bits of byte 2.
   - `uart_tx` is 1 in the same cycle; `busy`=0 and `word_ready`=1 after release.
   - The next word sends cleanly starting from byte 0.
6. **Nibble boundaries:** word 0x09AF0A9F in hex mode.
   - Produces "09AF0A9F": 0x30 0x39 0x41 0x46 0x30 0x41 0x39 0x46, then 0x0D 0x0A.
